axi4_lite_master_arbiter: RTL and testbench
===========================================

AXI4_LITE_MASTER_ARBITER -- requirements
Module: axi4_lite_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of requesters, legal range 2..4.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit; used only when ARB_TIMEOUT_EN is defined.
REQ-005 SHALL have ports, in order:
 clk  in  1  single clock, rising edge
 rst  in  1  asynchronous, active-low reset (asserted at 0)
 req_valid  in  NUM_REQ  per-requester request valid
 req_write  in  NUM_REQ  1 = write, 0 = read
 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
 req_strobe  in  NUM_REQ*4  packed byte strobes
 req_ready  out  NUM_REQ  one-hot accept pulse
 resp_valid  out  NUM_REQ  one-hot completion pulse
 resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
 resp_err  out  1  timeout flag, valid with resp_valid
 write_start  out  1  write launch pulse to peripheral top
 write_addr / write_data / write_strobe  out  ADDR_WIDTH / DATA_WIDTH / 4  write fields
 write_busy  in  1  write in progress
 read_start  out  1  read launch pulse
 read_addr  out  ADDR_WIDTH  read address
 read_data  in  DATA_WIDTH  read result
 read_busy  in  1  read in progress

Function
REQ-006 SHALL serve one transaction at a time; FSM states IDLE, ISSUE, SETTLE, WAIT, RESP.
REQ-007 IDLE: if any req_valid, SHALL grant by round-robin, assert req_ready[g] that cycle, latch g, req_write, addr, wdata, strobe; go ISSUE.
REQ-008 Round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset, requester 0 has highest priority.
REQ-009 ISSUE: exactly one cycle; write_start=1 if latched write, else read_start=1; never both; go SETTLE.
REQ-010 SETTLE: one cycle, busy ignored; go WAIT.
REQ-011 WAIT: stay while selected busy (write_busy or read_busy per direction) is 1; on 0, capture read_data (reads) or 0 (writes) into resp_rdata; go RESP.
REQ-012 RESP: one cycle, resp_valid[g]=1, resp_err per REQ-020; go IDLE.
REQ-013 Minimum latency accept-to-resp_valid SHALL be 4 cycles; next accept may occur the cycle after RESP.
REQ-014 write_addr/write_data/write_strobe/read_addr SHALL be registered and held stable from ISSUE until the next accept; unused-direction fields hold previous value.
REQ-015 req_valid deasserted before accept SHALL be dropped silently; requester fields need only be stable while req_valid=1 and not yet accepted.
REQ-016 Requests arriving in non-IDLE states SHALL wait; req_ready SHALL stay 0.
REQ-017 Busy asserted on the unselected direction SHALL be ignored.

Reset
REQ-018 rst=0 SHALL asynchronously force IDLE, all outputs 0, last_grant = NUM_REQ-1, timeout counter 0.
REQ-019 Reset mid-transaction SHALL abort without resp_valid; requester must re-present.

Configuration
REQ-020 Macro ARB_TIMEOUT_EN defined: counter counts WAIT cycles; at TIMEOUT_CYCLES go RESP with resp_err=1, resp_rdata=0; counter clears on entering WAIT. Undefined: no counter, WAIT unbounded, resp_err tied 0.

Verification
REQ-021 req_valid[0]=1 write 0x04/0xAABBCCDD/4'hF, busy high 3 cycles -> single write_start pulse with those fields, resp_valid[0] pulse, resp_err=0.
REQ-022 req_valid[1]=1 read 0x104, read_data=0xDDCBBBAA when busy falls -> single read_start, resp_rdata=0xDDCBBBAA with resp_valid[1].
REQ-023 Both req_valid held continuously, 4 transactions -> grants 0,1,0,1; no overlap of start pulses.
REQ-024 rst=0 during WAIT -> outputs 0 immediately, no resp_valid; after release, port 0 granted first.
REQ-025 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, read_busy stuck 1 -> resp_valid after 8 WAIT cycles, resp_err=1, resp_rdata=0; without macro -> no response within 100 cycles.
REQ-026 busy already low at SETTLE exit -> resp_valid exactly 4 cycles after req_ready.

Source files
------------

// File: rtl/axi4_lite_master_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_arbiter
//
// Purpose:
//   Arbitrates between NUM_REQ simple requesters and a single peripheral
//   access engine. Only one transaction is in flight at a time. Requesters
//   are granted round-robin, starting from the one after the last grant.
//   Each accepted request becomes one write_start or read_start pulse.
//   When the engine reports not-busy, the result goes back to the granted
//   requester as a one-cycle resp_valid pulse.
//
//   Transaction timeline (minimum latency is 4 cycles accept -> resp_valid):
//     IDLE (accept) -> ISSUE (start pulse) -> SETTLE (busy ignored)
//     -> WAIT (until busy drops) -> RESP (resp_valid) -> IDLE
//
// Optional feature:
//   ARB_TIMEOUT_EN - when defined, a watchdog counts WAIT cycles. After
//   TIMEOUT_CYCLES cycles the transaction finishes with resp_err=1 and
//   resp_rdata=0. When undefined, WAIT is unbounded and resp_err is tied 0.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   req_valid     in   [NUM_REQ]            request valid per requester
//   req_write     in   [NUM_REQ]            1 = write, 0 = read
//   req_addr      in   [NUM_REQ*ADDR_WIDTH] packed addresses
//   req_wdata     in   [NUM_REQ*DATA_WIDTH] packed write data
//   req_strobe    in   [NUM_REQ*4]          packed byte strobes
//   req_ready     out  [NUM_REQ]            one-hot accept pulse
//   resp_valid    out  [NUM_REQ]            one-hot completion pulse
//   resp_rdata    out  [DATA_WIDTH]         read data, valid with resp_valid
//   resp_err      out                       timeout flag, valid with resp_valid
//   write_start   out                       write launch pulse
//   write_addr    out  [ADDR_WIDTH]         write address
//   write_data    out  [DATA_WIDTH]         write data
//   write_strobe  out  [4]                  write byte strobes
//   write_busy    in                        write in progress
//   read_start    out                       read launch pulse
//   read_addr     out  [ADDR_WIDTH]         read address
//   read_data     in   [DATA_WIDTH]         read result
//   read_busy     in                        read in progress
// ---------------------------------------------------------------------------
module axi4_lite_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]           req_strobe,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           resp_err,
  output logic                           write_start,
  output logic [ADDR_WIDTH-1:0]          write_addr,
  output logic [DATA_WIDTH-1:0]          write_data,
  output logic [3:0]                     write_strobe,
  input  logic                           write_busy,
  output logic                           read_start,
  output logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic [DATA_WIDTH-1:0]          read_data,
  input  logic                           read_busy
);

  localparam int GW = $clog2(NUM_REQ);

  // Parameter sanity check at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi4_lite_master_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t               state;
  state_t               next_state;

  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        sel_grant;
  logic                 sel_write;

  logic [GW-1:0]        rr_grant;
  logic                 rr_found;
  logic [GW-1:0]        rr_idx;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [NUM_REQ-1:0]   sel_onehot;

  logic                 accept;
  logic                 sel_busy;
  logic                 timeout_hit;
  logic                 wait_exit;

  // Round-robin search. The search starts one past the last grant, so a
  // requester that was just served has the lowest priority next time.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      rr_idx = GW'((int'(last_grant) + off) % NUM_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_grant;
  assign sel_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_grant;

  // The accept is gated with rst so req_ready stays low while reset is held,
  // even though the state register already reads IDLE.
  assign accept    = rst && (state == IDLE) && rr_found;
  assign sel_busy  = sel_write ? write_busy : read_busy;
  assign wait_exit = (state == WAIT) && (!sel_busy || timeout_hit);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the pulse outputs decoded from the current state.
  always_comb begin
    next_state  = state;
    req_ready   = '0;
    write_start = 1'b0;
    read_start  = 1'b0;
    resp_valid  = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          req_ready  = grant_onehot;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        write_start = sel_write;
        read_start  = !sel_write;
        next_state  = SETTLE;
      end
      SETTLE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_exit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        resp_valid = sel_onehot;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant bookkeeping and the registered request fields. Only the fields of
  // the accepted direction are updated. The other direction keeps its old
  // contents, so the peripheral sees stable values until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= GW'(NUM_REQ - 1);
      sel_grant    <= '0;
      sel_write    <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_strobe <= '0;
      read_addr    <= '0;
    end else if (accept) begin
      last_grant <= rr_grant;
      sel_grant  <= rr_grant;
      sel_write  <= req_write[rr_grant];
      if (req_write[rr_grant]) begin
        write_addr   <= req_addr[rr_grant*ADDR_WIDTH +: ADDR_WIDTH];
        write_data   <= req_wdata[rr_grant*DATA_WIDTH +: DATA_WIDTH];
        write_strobe <= req_strobe[rr_grant*4 +: 4];
      end else begin
        read_addr <= req_addr[rr_grant*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Response data is captured on the WAIT exit. Writes and timed-out
  // transactions return zero. The value is held until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
    end else if (wait_exit) begin
      resp_rdata <= (sel_write || timeout_hit) ? '0 : read_data;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_count;
  logic          err_q;

  // The counter value equals the number of WAIT cycles already spent. The
  // watchdog fires in the TIMEOUT_CYCLES-th WAIT cycle if busy is still high.
  assign timeout_hit = (state == WAIT) && sel_busy &&
                       (to_count == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, cleared in SETTLE so each WAIT phase starts at zero.
  // The error flag is captured on the WAIT exit and presented in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_count <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == SETTLE) begin
        to_count <= '0;
      end else if ((state == WAIT) && !timeout_hit) begin
        to_count <= to_count + 1'b1;
      end
      if (wait_exit) begin
        err_q <= timeout_hit;
      end
    end
  end

  assign resp_err = (state == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_arbiter
//
// Directed bench for axi4_lite_master_arbiter with two requesters. It covers:
//   - reset values
//   - a single write and a single read, including timing and field contents
//   - alternating round-robin grants with both requesters always valid
//   - reset during WAIT
//   - a stuck busy (timeout when ARB_TIMEOUT_EN is defined, otherwise WAIT
//     is unbounded)
// Inputs are driven 2 time units after the rising edge. Outputs are sampled
// 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*4-1:0]   req_strobe;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              resp_err;
  logic              write_start;
  logic [AW-1:0]     write_addr;
  logic [DW-1:0]     write_data;
  logic [3:0]        write_strobe;
  logic              write_busy;
  logic              read_start;
  logic [AW-1:0]     read_addr;
  logic [DW-1:0]     read_data;
  logic              read_busy;

  int checks = 0;
  int errors = 0;

  axi4_lite_master_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_strobe(req_strobe),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .write_start(write_start),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_strobe(write_strobe),
    .write_busy(write_busy),
    .read_start(read_start),
    .read_addr(read_addr),
    .read_data(read_data),
    .read_busy(read_busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // One comparison: count it, and on a difference count and report it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 2 units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request on one requester port.
  task automatic applyStimulus(input int port, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [3:0] strb);
    req_valid[port]             = 1'b1;
    req_write[port]             = wr;
    req_addr[port*AW +: AW]     = addr;
    req_wdata[port*DW +: DW]    = wdata;
    req_strobe[port*4 +: 4]     = strb;
  endtask

  // Run one transaction from an IDLE cycle with requests already driven.
  // The selected busy is held high for cycles 1..busy_hold after the accept
  // (cycle 1 is ISSUE). noise holds the other direction's busy high. The task
  // returns during the resp_valid cycle, or after max_cycles without a response.
  task automatic doTxn(input logic dir_write, input int busy_hold, input logic noise,
                       input logic drop_req, input int max_cycles,
                       output int lat, output logic [NR-1:0] ready_seen,
                       output logic [NR-1:0] resp_seen, output int ws, output int rs,
                       output int both, output int late_ready,
                       output logic [DW-1:0] rdata_seen, output logic err_seen);
    #1;
    ready_seen = req_ready;
    lat        = 0;
    ws         = 0;
    rs         = 0;
    both       = 0;
    late_ready = 0;
    resp_seen  = '0;
    rdata_seen = '0;
    err_seen   = 1'b0;
    while (lat < max_cycles && resp_seen == '0) begin
      @(posedge clk);
      #2;
      lat++;
      if (lat == 1 && drop_req) req_valid = '0;
      if (dir_write) begin
        write_busy = (lat <= busy_hold);
        read_busy  = noise;
      end else begin
        read_busy  = (lat <= busy_hold);
        write_busy = noise;
      end
      #1;
      ws         += int'(write_start);
      rs         += int'(read_start);
      both       += int'(write_start && read_start);
      late_ready += int'(req_ready != '0);
      if (resp_valid != '0) begin
        resp_seen  = resp_valid;
        rdata_seen = resp_rdata;
        err_seen   = resp_err;
      end
    end
    if (dir_write) read_busy = 1'b0;
    else           write_busy = 1'b0;
  endtask

  int              lat;
  int              ws;
  int              rs;
  int              both;
  int              late_ready;
  logic [NR-1:0]   ready_seen;
  logic [NR-1:0]   resp_seen;
  logic [DW-1:0]   rdata_seen;
  logic            err_seen;

  // Directed sequence.
  initial begin
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_strobe = '0;
    write_busy = 1'b0;
    read_busy  = 1'b0;
    read_data  = '0;

    // Reset: outputs are zero, even with requests pending.
    req_valid = 2'b11;
    tick();
    tick();
    #1;
    checkOutput("rst_req_ready",    64'(req_ready),    64'h0);
    checkOutput("rst_write_start",  64'(write_start),  64'h0);
    checkOutput("rst_read_start",   64'(read_start),   64'h0);
    checkOutput("rst_resp_valid",   64'(resp_valid),   64'h0);
    checkOutput("rst_resp_rdata",   64'(resp_rdata),   64'h0);
    checkOutput("rst_resp_err",     64'(resp_err),     64'h0);
    checkOutput("rst_write_addr",   64'(write_addr),   64'h0);
    checkOutput("rst_read_addr",    64'(read_addr),    64'h0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    // Single write on port 0, busy high for 3 cycles: RESP at cycle 5.
    $display("[TB] single write on port 0");
    applyStimulus(0, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'hF);
    doTxn(1'b1, 3, 1'b0, 1'b1, 20, lat, ready_seen, resp_seen, ws, rs, both, late_ready,
          rdata_seen, err_seen);
    checkOutput("wr_ready",       64'(ready_seen),   64'h1);
    checkOutput("wr_latency",     64'(lat),          64'd5);
    checkOutput("wr_resp_valid",  64'(resp_seen),    64'h1);
    checkOutput("wr_start_count", 64'(ws),           64'd1);
    checkOutput("wr_no_read",     64'(rs),           64'd0);
    checkOutput("wr_resp_err",    64'(err_seen),     64'h0);
    checkOutput("wr_resp_rdata",  64'(rdata_seen),   64'h0);
    checkOutput("wr_addr",        64'(write_addr),   64'h4);
    checkOutput("wr_data",        64'(write_data),   64'hAABB_CCDD);
    checkOutput("wr_strobe",      64'(write_strobe), 64'hF);
    checkOutput("wr_busy_ready",  64'(late_ready),   64'd0);
    tick();
    #1;
    checkOutput("wr_resp_pulse",  64'(resp_valid),   64'h0);

    // Single read on port 1, busy for 4 cycles: RESP at cycle 6. The write
    // busy is held high throughout and must be ignored.
    $display("[TB] single read on port 1");
    applyStimulus(1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    read_data = 32'hDDCB_BBAA;
    doTxn(1'b0, 4, 1'b1, 1'b1, 20, lat, ready_seen, resp_seen, ws, rs, both, late_ready,
          rdata_seen, err_seen);
    checkOutput("rd_ready",       64'(ready_seen),   64'h2);
    checkOutput("rd_latency",     64'(lat),          64'd6);
    checkOutput("rd_resp_valid",  64'(resp_seen),    64'h2);
    checkOutput("rd_start_count", 64'(rs),           64'd1);
    checkOutput("rd_no_write",    64'(ws),           64'd0);
    checkOutput("rd_resp_rdata",  64'(rdata_seen),   64'hDDCB_BBAA);
    checkOutput("rd_resp_err",    64'(err_seen),     64'h0);
    checkOutput("rd_addr",        64'(read_addr),    64'h104);
    checkOutput("rd_wr_addr_hold",64'(write_addr),   64'h4);
    tick();

    // Both requesters held valid: grants alternate 0,1,0,1 at minimum latency.
    $display("[TB] round-robin with both requesters valid");
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'h3);
    applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    read_data = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      doTxn((k % 2) == 0, ((k % 2) == 0) ? 0 : 2, 1'b0, 1'b0, 20, lat, ready_seen,
            resp_seen, ws, rs, both, late_ready, rdata_seen, err_seen);
      checkOutput($sformatf("rr%0d_ready", k),   64'(ready_seen), 64'(1 << (k % 2)));
      checkOutput($sformatf("rr%0d_resp", k),    64'(resp_seen),  64'(1 << (k % 2)));
      checkOutput($sformatf("rr%0d_latency", k), 64'(lat),        64'd4);
      checkOutput($sformatf("rr%0d_starts", k),  64'(ws + rs),    64'd1);
      checkOutput($sformatf("rr%0d_overlap", k), 64'(both),       64'd0);
      checkOutput($sformatf("rr%0d_hold_rdy", k),64'(late_ready), 64'd0);
      checkOutput($sformatf("rr%0d_rdata", k),   64'(rdata_seen),
                  ((k % 2) == 0) ? 64'h0 : 64'h1234_5678);
      tick();
    end
    req_valid = '0;
    checkOutput("rr_wr_addr", 64'(write_addr), 64'h10);
    checkOutput("rr_rd_addr", 64'(read_addr),  64'h20);

    // Reset during WAIT: everything clears at once, no response appears, and
    // port 0 wins again afterwards.
    $display("[TB] reset during WAIT");
    applyStimulus(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    #1;
    checkOutput("ab_ready", 64'(req_ready), 64'h1);
    tick();
    #1;
    checkOutput("ab_read_start", 64'(read_start), 64'h1);
    req_valid = '0;
    read_busy = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("ab_read_addr",  64'(read_addr),  64'h0);
    checkOutput("ab_write_addr", 64'(write_addr), 64'h0);
    checkOutput("ab_resp_rdata", 64'(resp_rdata), 64'h0);
    checkOutput("ab_resp_valid", 64'(resp_valid), 64'h0);
    tick();
    tick();
    #1;
    checkOutput("ab_no_resp", 64'(resp_valid), 64'h0);
    rst = 1'b1;
    read_busy = 1'b0;
    applyStimulus(0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hC);
    applyStimulus(1, 1'b1, 32'h0000_0040, 32'h0BAD_BEEF, 4'h1);
    doTxn(1'b1, 0, 1'b0, 1'b1, 20, lat, ready_seen, resp_seen, ws, rs, both, late_ready,
          rdata_seen, err_seen);
    checkOutput("ab_after_ready",   64'(ready_seen), 64'h1);
    checkOutput("ab_after_resp",    64'(resp_seen),  64'h1);
    checkOutput("ab_after_latency", 64'(lat),        64'd4);
    checkOutput("ab_after_addr",    64'(write_addr), 64'h30);
    checkOutput("ab_after_data",    64'(write_data), 64'hCAFE_F00D);
    tick();
    tick();
    #1;
    checkOutput("ab_dropped_ready", 64'(req_ready),  64'h0);
    checkOutput("ab_dropped_resp",  64'(resp_valid), 64'h0);

    // Stuck read busy on port 1.
    $display("[TB] stuck read busy");
    applyStimulus(1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    read_data = 32'h55AA_55AA;
`ifdef ARB_TIMEOUT_EN
    doTxn(1'b0, 1000, 1'b0, 1'b1, 40, lat, ready_seen, resp_seen, ws, rs, both, late_ready,
          rdata_seen, err_seen);
    checkOutput("to_ready",   64'(ready_seen), 64'h2);
    checkOutput("to_latency", 64'(lat),        64'd11);
    checkOutput("to_resp",    64'(resp_seen),  64'h2);
    checkOutput("to_err",     64'(err_seen),   64'h1);
    checkOutput("to_rdata",   64'(rdata_seen), 64'h0);
    read_busy = 1'b0;
    tick();
    #1;
    checkOutput("to_err_pulse", 64'(resp_err), 64'h0);
`else
    doTxn(1'b0, 1000, 1'b0, 1'b1, 100, lat, ready_seen, resp_seen, ws, rs, both, late_ready,
          rdata_seen, err_seen);
    checkOutput("stuck_ready",   64'(ready_seen), 64'h2);
    checkOutput("stuck_no_resp", 64'(resp_seen),  64'h0);
    checkOutput("stuck_cycles",  64'(lat),        64'd100);
    read_busy = 1'b0;
    tick();
    #1;
    checkOutput("stuck_release_resp",  64'(resp_valid), 64'h2);
    checkOutput("stuck_release_rdata", 64'(resp_rdata), 64'h55AA_55AA);
    checkOutput("stuck_release_err",   64'(resp_err),   64'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
